// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: programmable VGA timing sequencer with a shadowed config bank.
// Optional macro VGA_SYNC_POL_EN adds a shadowed sync-polarity register at address 8.
module vga_timing_ctrl #(
    parameter int REZ_MAX_WIDTH = 11,
`ifdef VGA_SYNC_POL_EN
    parameter int CFG_AW        = 4,
`else
    parameter int CFG_AW        = 3,
`endif
    parameter int DEF_H_MAX     = 799,
    parameter int DEF_HS_END    = 95,
    parameter int DEF_HA_START  = 144,
    parameter int DEF_HA_END    = 783,
    parameter int DEF_V_MAX     = 524,
    parameter int DEF_VS_END    = 1,
    parameter int DEF_VA_START  = 35,
    parameter int DEF_VA_END    = 514
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pix_ce,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [CFG_AW-1:0]        cfg_addr,
    input  logic [REZ_MAX_WIDTH-1:0] cfg_data,
    input  logic                     cfg_commit,
    output logic [REZ_MAX_WIDTH-1:0] Count_h,
    output logic [REZ_MAX_WIDTH-1:0] Count_v,
    output logic [REZ_MAX_WIDTH-1:0] H_left_margin,
    output logic [REZ_MAX_WIDTH-1:0] H_right_margin,
    output logic [REZ_MAX_WIDTH-1:0] V_left_margin,
    output logic [REZ_MAX_WIDTH-1:0] V_right_margin,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     frame_start,
    output logic                     cfg_applied
);

    localparam int W = REZ_MAX_WIDTH;

    typedef logic [W-1:0] word_t;

    localparam int A_H_MAX    = 0;
    localparam int A_HS_END   = 1;
    localparam int A_HA_START = 2;
    localparam int A_HA_END   = 3;
    localparam int A_V_MAX    = 4;
    localparam int A_VS_END   = 5;
    localparam int A_VA_START = 6;
    localparam int A_VA_END   = 7;

    localparam word_t C_DEF [8] = '{
        word_t'(DEF_H_MAX),
        word_t'(DEF_HS_END),
        word_t'(DEF_HA_START),
        word_t'(DEF_HA_END),
        word_t'(DEF_V_MAX),
        word_t'(DEF_VS_END),
        word_t'(DEF_VA_START),
        word_t'(DEF_VA_END)
    };

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    word_t  r_shadow [8];
    word_t  r_live   [8];
    word_t  r_count_h;
    word_t  r_count_v;
    logic   r_hsync;
    logic   r_vsync;
    logic   r_frame_start;
    logic   r_cfg_applied;

    logic   w_pending;
    logic   w_xfer;
    logic   w_wr;
    logic   w_commit;
    logic   w_addr_tim;
    logic   w_h_end;
    logic   w_v_end;
    logic   w_wrap;
    logic   w_apply;
    logic   w_hs_act;
    logic   w_vs_act;
    logic   w_hs_lvl;
    logic   w_vs_lvl;

    assign w_pending = (r_state == S_PEND);
    assign w_xfer    = cfg_valid & ~w_pending;
    assign w_wr      = w_xfer & ~cfg_commit;
    assign w_commit  = w_xfer & cfg_commit;

    assign w_h_end   = (r_count_h >= r_live[A_H_MAX]);
    assign w_v_end   = (r_count_v >= r_live[A_V_MAX]);
    assign w_wrap    = pix_ce & w_h_end & w_v_end;
    // Only a commit already pending before the wrap edge goes live here.
    assign w_apply   = w_wrap & w_pending;

    assign w_hs_act  = (r_count_h <= r_live[A_HS_END]);
    assign w_vs_act  = (r_count_v <= r_live[A_VS_END]);

`ifdef VGA_SYNC_POL_EN
    logic [1:0] r_pol_shadow;
    logic [1:0] r_pol_live;
    logic       w_addr_pol;

    assign w_addr_tim = (cfg_addr[CFG_AW-1:3] == '0);
    assign w_addr_pol = (cfg_addr == CFG_AW'(8));
    assign w_hs_lvl   = w_hs_act ~^ r_pol_live[0];
    assign w_vs_lvl   = w_vs_act ~^ r_pol_live[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pol_shadow <= 2'b00;
            r_pol_live   <= 2'b00;
        end else begin
            if (w_wr && w_addr_pol) begin
                r_pol_shadow <= cfg_data[1:0];
            end
            if (w_apply) begin
                r_pol_live <= r_pol_shadow;
            end
        end
    end
`else
    assign w_addr_tim = 1'b1;
    assign w_hs_lvl   = ~w_hs_act;
    assign w_vs_lvl   = ~w_vs_act;
`endif

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_commit) begin
                    w_state_nx = S_PEND;
                end
            end
            S_PEND: begin
                if (w_apply) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= C_DEF;
            r_live   <= C_DEF;
        end else begin
            if (w_wr && w_addr_tim) begin
                r_shadow[cfg_addr[2:0]] <= cfg_data;
            end
            if (w_apply) begin
                r_live <= r_shadow;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count_h <= '0;
            r_count_v <= '0;
        end else if (pix_ce) begin
            if (w_h_end) begin
                r_count_h <= '0;
                r_count_v <= w_v_end ? '0 : r_count_v + 1'b1;
            end else begin
                r_count_h <= r_count_h + 1'b1;
            end
        end
    end

    // Syncs lag the counters by one pixel to line up with the colour stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else if (pix_ce) begin
            r_hsync <= w_hs_lvl;
            r_vsync <= w_vs_lvl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_start <= 1'b0;
            r_cfg_applied <= 1'b0;
        end else begin
            r_frame_start <= w_wrap;
            r_cfg_applied <= w_apply;
        end
    end

    assign cfg_ready      = ~w_pending;
    assign Count_h        = r_count_h;
    assign Count_v        = r_count_v;
    assign H_left_margin  = r_live[A_HA_START];
    assign H_right_margin = r_live[A_HA_END];
    assign V_left_margin  = r_live[A_VA_START];
    assign V_right_margin = r_live[A_VA_END];
    assign hsync          = r_hsync;
    assign vsync          = r_vsync;
    assign frame_start    = r_frame_start;
    assign cfg_applied    = r_cfg_applied;

endmodule
